// File: rtl/data_mem_ctrl.sv
// Byte-addressable data memory controller: sized, aligned reads and writes with
// sign/zero extension, misalignment rejection and a configurable read latency.
module data_mem_ctrl #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clka,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              ack,
    output logic              err,
    output logic [DATA_W-1:0] rdata
);

    localparam int NB    = DATA_W / 8;
    localparam int LB    = $clog2(NB);
    localparam int WORDS = 2 ** (ADDR_W - LB);
    localparam logic [1:0] WAIT_INIT = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

    if (!(DATA_W == 32 || DATA_W == 64)) begin : g_bad_data_w
        $error("data_mem_ctrl: DATA_W must be 32 or 64");
    end
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
        $error("data_mem_ctrl: RD_LAT must be in 1..4");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } state_t;

    state_t              state_r, state_next_s;
    logic [1:0]          wait_cnt_r, wait_cnt_next_s;
    logic                ack_r, err_r;
    logic [DATA_W-1:0]   rdata_r;
    logic                accept_s, err_req_s, wr_en_s;
    logic                ack_next_s, err_next_s, rd_load_s;
    logic [LB-1:0]       off_s, off_r, fmt_off_s;
    logic [1:0]          size_r, fmt_size_s;
    logic                sext_r, fmt_sext_s;
    logic [ADDR_W-LB-1:0] widx_s;
    logic [NB-1:0]       be_s;
    logic [DATA_W-1:0]   wsh_s, mem_word_s, rd_word_r, rd_src_s;
    logic [DATA_W-1:0]   mem_r [0:WORDS-1];

    function automatic int size_bytes(input logic [1:0] sz);
        case (sz)
            2'd0:    size_bytes = 1;
            2'd1:    size_bytes = 2;
            2'd2:    size_bytes = 4;
            default: size_bytes = 8;
        endcase
    endfunction

    // Right-align the addressed lanes, then fill the upper bits with zero or the sub-word MSB.
    function automatic logic [DATA_W-1:0] fmt_read(
        input logic [DATA_W-1:0] word,
        input logic [LB-1:0]     off,
        input logic [1:0]        sz,
        input logic              sx
    );
        logic [DATA_W-1:0] sh;
        logic [DATA_W-1:0] keep;
        logic              ext;
        int                nbits;
        sh    = word >> {off, 3'b000};
        nbits = 8 * size_bytes(sz);
        keep  = (nbits >= DATA_W) ? {DATA_W{1'b1}}
                                  : (({{(DATA_W-1){1'b0}}, 1'b1} << nbits) - {{(DATA_W-1){1'b0}}, 1'b1});
        case (sz)
            2'd0:    ext = sx & sh[7];
            2'd1:    ext = sx & sh[15];
            2'd2:    ext = sx & sh[31];
            default: ext = 1'b0;
        endcase
        fmt_read = (sh & keep) | ({DATA_W{ext}} & ~keep);
    endfunction

    assign ready      = (state_r == IDLE) && rst_n;
    assign accept_s   = req && ready;
    assign off_s      = addr[LB-1:0];
    assign widx_s     = addr[ADDR_W-1:LB];
    assign mem_word_s = mem_r[widx_s];
    assign wr_en_s    = accept_s && we && !err_req_s;
    assign ack        = ack_r;
    assign err        = err_r;
    assign rdata      = rdata_r;

    // Alignment check of the incoming request.
    always_comb begin
        err_req_s = 1'b0;
        case (size)
            2'd0:    err_req_s = 1'b0;
            2'd1:    err_req_s = addr[0];
            2'd2:    err_req_s = (addr[1:0] != 2'b00);
            2'd3:    err_req_s = (DATA_W == 32) || (addr[2:0] != 3'b000);
            default: err_req_s = 1'b0;
        endcase
    end

    // Byte enables and lane-shifted write data.
    always_comb begin
        wsh_s = wdata << {off_s, 3'b000};
        be_s  = '0;
        for (int i = 0; i < NB; i++) begin
            if (i >= int'(off_s) && i < int'(off_s) + size_bytes(size)) begin
                be_s[i] = 1'b1;
            end else begin
                be_s[i] = 1'b0;
            end
        end
    end

    // Byte-lane write port; the array itself is never reset.
    always_ff @(posedge clka) begin
        if (wr_en_s) begin
            for (int i = 0; i < NB; i++) begin
                if (be_s[i]) begin
                    mem_r[widx_s][8*i +: 8] <= wsh_s[8*i +: 8];
                end
            end
        end
    end

    // Next-state and response decode.
    always_comb begin
        state_next_s    = state_r;
        wait_cnt_next_s = wait_cnt_r;
        ack_next_s      = 1'b0;
        err_next_s      = 1'b0;
        rd_load_s       = 1'b0;
        rd_src_s        = rd_word_r;
        fmt_off_s       = off_r;
        fmt_size_s      = size_r;
        fmt_sext_s      = sext_r;
        case (state_r)
            IDLE: begin
                // A single-cycle read formats straight from the array and live inputs.
                rd_src_s   = mem_word_s;
                fmt_off_s  = off_s;
                fmt_size_s = size;
                fmt_sext_s = sext;
                if (accept_s) begin
                    if (err_req_s) begin
                        state_next_s = RESP;
                        ack_next_s   = 1'b1;
                        err_next_s   = 1'b1;
                    end else if (we) begin
                        state_next_s = RESP;
                        ack_next_s   = 1'b1;
                    end else if (RD_LAT == 1) begin
                        state_next_s = RESP;
                        ack_next_s   = 1'b1;
                        rd_load_s    = 1'b1;
                    end else begin
                        state_next_s    = RD_WAIT;
                        wait_cnt_next_s = WAIT_INIT;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            RD_WAIT: begin
                if (wait_cnt_r == 2'd0) begin
                    state_next_s = RESP;
                    ack_next_s   = 1'b1;
                    rd_load_s    = 1'b1;
                end else begin
                    wait_cnt_next_s = wait_cnt_r - 2'd1;
                end
            end
            RESP:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Control state, registered responses and the request capture.
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            wait_cnt_r <= 2'd0;
            ack_r      <= 1'b0;
            err_r      <= 1'b0;
            rdata_r    <= '0;
            off_r      <= '0;
            size_r     <= 2'd0;
            sext_r     <= 1'b0;
            rd_word_r  <= '0;
        end else begin
            state_r    <= state_next_s;
            wait_cnt_r <= wait_cnt_next_s;
            ack_r      <= ack_next_s;
            err_r      <= err_next_s;
            if (rd_load_s) begin
                rdata_r <= fmt_read(rd_src_s, fmt_off_s, fmt_size_s, fmt_sext_s);
            end
            if (accept_s) begin
                off_r     <= off_s;
                size_r    <= size;
                sext_r    <= sext;
                rd_word_r <= mem_word_s;
            end
        end
    end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter ADDR_W, 12, byte-address width; array holds 2**ADDR_W bytes, organised as DATA_W-wide words.
REQ-002 Parameter DATA_W, 32, word width; SHALL be 32 or 64; any other value is an elaboration error.
REQ-003 Parameter RD_LAT, 1, read latency in cycles from accept edge to ack; legal range 1..4.
REQ-004 clka  in  1  single clock; all state changes on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 req  in  1  access request.
REQ-007 we  in  1  1 = write, 0 = read.
REQ-008 size  in  2  access size: 0 byte, 1 half, 2 word32, 3 dword64.
REQ-009 sext  in  1  reads only: 1 sign-extends sub-word data, 0 zero-extends.
REQ-010 addr  in  ADDR_W  byte address, little-endian lane order.
REQ-011 wdata  in  DATA_W  write data, right-aligned; only the low size-bytes are used.
REQ-012 ready  out  1  controller idle and able to accept.
REQ-013 ack  out  1  one-cycle completion pulse for every accepted request.
REQ-014 err  out  1  qualifies ack; 1 = request rejected, no memory access.
REQ-015 rdata  out  DATA_W  read result; valid while ack=1 and err=0.

Function
REQ-016 Accept edge: rising clka edge with req=1, ready=1, rst_n=1; all inputs sampled there, ignored at all other times.
REQ-017 FSM states: IDLE, RD_WAIT, RESP; ready = (state==IDLE) and rst_n=1.
REQ-018 Error request (half with addr[0]=1, word32 with addr[1:0]!=0, dword64 with addr[2:0]!=0, dword64 when DATA_W=32): IDLE->RESP, ack=1, err=1 in the next cycle, memory and rdata unchanged.
REQ-019 Valid write: byte lanes committed at the accept edge; only addressed lanes change; IDLE->RESP, ack=1, err=0 in the next cycle; rdata unchanged.
REQ-020 Valid read: IDLE->RD_WAIT for RD_LAT-1 cycles (RD_WAIT skipped when RD_LAT=1), then RESP; ack rises exactly RD_LAT cycles after the accept edge.
REQ-021 Read data: addressed lanes right-aligned into rdata; upper bits copy the sub-word MSB when sext=1, else 0; sext ignored for full-width reads.
REQ-022 RESP lasts exactly one cycle, then IDLE; ack and err are 0 in every other state.
REQ-023 rdata is registered and holds its last successful read value until the next successful read ack.
REQ-024 A read always returns data written by any earlier accepted write, including a write to the same address accepted immediately before.
REQ-025 Max throughput: one write every 2 cycles, one read every RD_LAT+1 cycles with req held high.
REQ-026 Memory array is not reset; contents are undefined until written.

Reset
REQ-027 While rst_n=0: state=IDLE, ready=0, ack=0, err=0, rdata=0, counters cleared; effect is immediate, not clock-dependent.
REQ-028 Reset mid-read: the in-flight read is dropped and no ack is produced. Reset after a write's accept edge keeps the written data.
REQ-029 First accept is possible on the first rising edge where rst_n=1.

Verification (ADDR_W=12, DATA_W=32, RD_LAT=2)
REQ-030 Reset: rst_n low mid-cycle -> ready/ack/err/rdata = 0 before the next edge; release -> ready=1.
REQ-031 Word write 0xDEADBEEF @0x010, then word read @0x010 -> write ack 1 cycle after accept; read ack 2 cycles after accept, rdata=0xDEADBEEF, err=0.
REQ-032 Byte write 0x80 @0x013 -> signed byte read @0x013 gives 0xFFFFFF80; unsigned gives 0x00000080; word read @0x010 gives 0x80ADBEEF.
REQ-033 Half read @0x011 and word write 0x12345678 @0x012 -> each gets ack=1, err=1 one cycle after accept; rdata unchanged; word @0x010 still 0x80ADBEEF; size=3 at @0x010 also errors.
REQ-034 Reset pulse during RD_WAIT of a read @0x010 -> no ack. A following read @0x010 returns 0x80ADBEEF.
REQ-035 req held high for 3 reads @0x010/0x014/0x018 -> accepts every 3 cycles, 3 acks, each 2 cycles after its accept, ready low between accepts.
